serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_if.sv | 37 +++
 rtl/serial_adder_fa_slice.sv | 26 ++
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// The optional subtract path is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width that stays legal when only one digit exists.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder_fa_slice.sv
// DIGIT-bit combinational ripple-carry adder; also exposes the carry into
// its top bit so the caller can derive signed overflow.
module fa_slice #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);
   logic [DIGIT:0] c;

   assign c[0] = ci;

   generate
      for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
         assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
         assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
      end
   endgenerate

   assign co       = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per cycle, LSB first, WIDTH/DIGIT cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b as a + ~b + 1).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int              NDIG = WIDTH / DIGIT;
   localparam int              CW   = cnt_width(NDIG);
   localparam logic [CW-1:0]   LAST = CW'(NDIG - 1);

   generate
      if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_param_check
         $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0] x_sl, y_sl, s_sl;
   logic             co_sl, cmsb_sl;

   always_comb begin
      x_sl = '0;
      y_sl = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (cnt_q == CW'(i)) begin
            x_sl = a_q[i*DIGIT +: DIGIT];
            y_sl = b_q[i*DIGIT +: DIGIT];
         end
      end
   end

   fa_slice #(.DIGIT(DIGIT)) u_fa (
      .x        (x_sl),
      .y        (y_sl),
      .ci       (carry_q),
      .s        (s_sl),
      .co       (co_sl),
      .c_msb_in (cmsb_sl)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d   = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
               // Subtraction reuses the adder: invert B and force carry-in.
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
`else
               b_d     = bus.b;
               carry_d = bus.cin;
`endif
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NDIG; i++) begin
               if (cnt_q == CW'(i)) begin
                  sum_d[i*DIGIT +: DIGIT] = s_sl;
               end
            end
            carry_d = co_sl;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               cout_d  = co_sl;
               ovf_d   = co_sl ^ cmsb_sl;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: 16/4 instance (tables, corner sequences, random ops)
// and an 8/8 instance swept over every A value.
module tb_serial_adder;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   serial_adder_if #(.WIDTH(16)) bus16 ();
   serial_adder_if #(.WIDTH(8))  bus8 ();

   serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Arithmetic reference: plain integer sums, signed range test for overflow.
   task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        output logic [15:0] s, output logic co, output logic ov);
      longint m, ua, ub, sa, sb, tot, st;
      m  = longint'(1) << w;
      ua = longint'(a) & (m - 1);
      ub = longint'(b) & (m - 1);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (sub) begin
         tot = ua - ub;
         co  = (ua >= ub);
         st  = sa - sb;
      end else begin
         tot = ua + ub + longint'(cin);
         co  = (tot >= m);
         st  = sa + sb + longint'(cin);
      end
      s  = 16'(tot & (m - 1));
      ov = (st >= m / 2) || (st < -(m / 2));
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input int hold, input bit noise,
                       output logic [15:0] s, output logic co, output logic ov,
                       output int lat);
      int g;
      g = 0;
      while (bus16.in_ready !== 1'b1 && g < 20) begin
         @(posedge clk); #1; g++;
      end
      chk("in_ready_before_op", 32'(bus16.in_ready), 32'd1);
      bus16.a        = a;
      bus16.b        = b;
      bus16.cin      = cin;
`ifdef SERIAL_ADDER_SUB_EN
      bus16.sub      = sub;
`endif
      bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      if (noise) begin
         bus16.a   = 16'($urandom);
         bus16.b   = 16'($urandom);
         bus16.cin = ~cin;
      end else begin
         bus16.in_valid = 1'b0;
      end
      lat = 0;
      while (bus16.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      s  = bus16.sum;
      co = bus16.cout;
      ov = bus16.ovf;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_sum_stable", 32'(bus16.sum), 32'(s));
         chk("hold_flags_stable", 32'({bus16.cout, bus16.ovf}), 32'({co, ov}));
         chk("hold_out_valid", 32'(bus16.out_valid), 32'd1);
         chk("hold_in_ready_low", 32'(bus16.in_ready), 32'd0);
      end
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
      bus16.in_valid  = 1'b0;
      chk("idle_after_exit", 32'({bus16.in_ready, bus16.out_valid}), 32'b10);
   endtask

   task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input int hold, input bit noise,
                        input logic [15:0] es, input logic eco, input logic eov);
      logic [15:0] s;
      logic        co, ov;
      int          lat;
      op16(a, b, cin, sub, hold, noise, s, co, ov, lat);
      $display("%s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               name, a, b, cin, sub, s, co, ov, lat);
      chk({name, "_sum"}, 32'(s), 32'(es));
      chk({name, "_cout"}, 32'(co), 32'(eco));
      chk({name, "_ovf"}, 32'(ov), 32'(eov));
      chk({name, "_latency"}, 32'(lat), 32'd4);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      logic [15:0] es;
      logic        eco, eov;
      int          lat;
      model(8, {8'h00, a}, {8'h00, b}, cin, 1'b0, es, eco, eov);
      bus8.a        = a;
      bus8.b        = b;
      bus8.cin      = cin;
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("w8_sum", 32'(bus8.sum), 32'(es[7:0]));
      chk("w8_cout", 32'(bus8.cout), 32'(eco));
      chk("w8_ovf", 32'(bus8.ovf), 32'(eov));
      chk("w8_latency", 32'(lat), 32'd1);
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
   endtask

   initial begin
      vec_t        vecs[$];
      logic [15:0] es;
      logic        eco, eov;
      logic [15:0] ra, rb;
      logic        rc, rs;
      logic [7:0]  blist[8];
      bit          rose;

      n_checks = 0;
      n_fail   = 0;

      vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
      vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
      vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
      vecs.push_back('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0});
      vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1});
      vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
      vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0});
      vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
      vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

      rst_n           = 1'b0;
      bus16.in_valid  = 1'b0;
      bus16.a         = '0;
      bus16.b         = '0;
      bus16.cin       = 1'b0;
      bus16.out_ready = 1'b0;
      bus8.in_valid   = 1'b0;
      bus8.a          = '0;
      bus8.b          = '0;
      bus8.cin        = 1'b0;
      bus8.out_ready  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      bus16.sub       = 1'b0;
      bus8.sub        = 1'b0;
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
      chk("rst_sum", 32'(bus16.sum), 32'd0);
      chk("rst_flags", 32'({bus16.cout, bus16.ovf}), 32'd0);
      chk("rst_w8_outputs", 32'({bus8.out_valid, bus8.cout, bus8.ovf, bus8.sum}), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(bus16.in_ready), 32'd1);
      chk("rst_w8_in_ready", 32'(bus8.in_ready), 32'd1);

      // Directed table
      foreach (vecs[i]) begin
         run16("vec", vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, 1'b0,
               vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      end

      // Back-pressure in DONE with in_valid pulsed; second operand must not land
      run16("hold3", 16'h1111, 16'h2222, 1'b0, 1'b0, 3, 1'b1, 16'h3333, 1'b0, 1'b0);

      // Reset during the second RUN cycle abandons the operation
      bus16.a        = 16'hFFFF;
      bus16.b        = 16'hFFFF;
      bus16.cin      = 1'b1;
      bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_sum", 32'(bus16.sum), 32'd0);
      chk("midrun_rst_flags", 32'({bus16.out_valid, bus16.cout, bus16.ovf}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rose = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus16.out_valid !== 1'b0) rose = 1'b1;
      end
      chk("midrun_rst_no_result", 32'(rose), 32'd0);
      chk("midrun_rst_in_ready", 32'(bus16.in_ready), 32'd1);
      run16("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Random operations against the arithmetic model
      for (int i = 0; i < 150; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         model(16, ra, rb, rc, rs, es, eco, eov);
         run16("rand", ra, rb, rc, rs, int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), es, eco, eov);
      end

      // WIDTH == DIGIT instance: every A value against edge and random B values
      for (int ai = 0; ai < 256; ai++) begin
         blist[0] = 8'h00;
         blist[1] = 8'h01;
         blist[2] = 8'h7F;
         blist[3] = 8'h80;
         blist[4] = 8'hFF;
         blist[5] = 8'($urandom);
         blist[6] = 8'($urandom);
         blist[7] = 8'($urandom);
         for (int bi = 0; bi < 8; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               run8(8'(ai), blist[bi], 1'(ci));
            end
         end
      end
      $display("w8 sweep: 4096 operations applied");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
